// File: rtl/ram_controller.sv
// Word-addressed data memory behind the MAR/MDR with a fixed-latency access sequencer.
// A request is captured in IDLE, then walks WAIT -> ACCESS -> DONE and pulses Done once.
module ram_controller #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] MDR_out,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] Mdatain,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              wr_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    logic accept;
    assign accept = (state_q == S_IDLE) && (Read || Write);

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Read || Write) begin
                        // Write takes priority; a simultaneous read is simply dropped.
                        wr_q    <= Write;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_INIT;
                        state_q <= NO_WAIT ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (!wr_q) begin
                        rdata_q <= mem_q[addr_q];
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Operands and storage carry no reset; an aborted write never reaches ACCESS.
    always_ff @(posedge Clock) begin
        if (accept) begin
            addr_q <= Address;
            data_q <= MDR_out;
        end
        if (state_q == S_ACCESS && wr_q) begin
            mem_q[addr_q] <= data_q;
        end
    end

    assign Mdatain = rdata_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_ram_controller.sv
// Directed bench for ram_controller: a WAIT_STATES=2 instance for the main sequence
// and a WAIT_STATES=0 instance for the zero-wait and back-to-back cases.
module tb_ram_controller;

    logic        Clock;
    logic        Clear;
    logic [8:0]  Address;
    logic [31:0] MDR_out;
    logic        Read;
    logic        Write;
    logic [31:0] Mdatain;
    logic        Busy;
    logic        Done;

    logic [8:0]  Address1;
    logic [31:0] MDR1;
    logic        Read1;
    logic        Write1;
    logic [31:0] Mdatain1;
    logic        Busy1;
    logic        Done1;

    int n_cmp = 0;
    int n_bad = 0;

    ram_controller #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(2)) dut (
        .Clock(Clock), .Clear(Clear), .Address(Address), .MDR_out(MDR_out),
        .Read(Read), .Write(Write), .Mdatain(Mdatain), .Busy(Busy), .Done(Done)
    );

    ram_controller #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .Clock(Clock), .Clear(Clear), .Address(Address1), .MDR_out(MDR1),
        .Read(Read1), .Write(Write1), .Mdatain(Mdatain1), .Busy(Busy1), .Done(Done1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // One request on the WAIT_STATES=2 instance; operands are scrambled right after
    // acceptance to show that only the captured values matter.
    task automatic op2(input string tag, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d,
                       input logic [31:0] exp_md);
        Read = rd; Write = wr; Address = a; MDR_out = d;
        cyc();
        Read = 1'b0; Write = 1'b0; Address = 9'h000; MDR_out = ~d;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s busy e+%0d", tag, k), {31'd0, Busy}, 32'd1);
            chk($sformatf("%s done e+%0d", tag, k), {31'd0, Done}, (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) chk($sformatf("%s mdatain", tag), Mdatain, exp_md);
            else        cyc();
        end
        cyc();
        chk($sformatf("%s busy idle", tag), {31'd0, Busy}, 32'd0);
        chk($sformatf("%s done idle", tag), {31'd0, Done}, 32'd0);
    endtask

    initial begin
        Clear = 1'b0;
        Read = 1'b0; Write = 1'b0; Address = 9'h000; MDR_out = 32'h0;
        Read1 = 1'b0; Write1 = 1'b0; Address1 = 9'h000; MDR1 = 32'h0;
        #1;
        chk("rst busy", {31'd0, Busy}, 32'd0);
        chk("rst done", {31'd0, Done}, 32'd0);
        chk("rst mdatain", Mdatain, 32'h0);
        cyc();
        cyc();
        Clear = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("idle%0d busy", i), {31'd0, Busy}, 32'd0);
            chk($sformatf("idle%0d done", i), {31'd0, Done}, 32'd0);
            chk($sformatf("idle%0d mdatain", i), Mdatain, 32'h0);
        end

        op2("wr1a5", 1'b0, 1'b1, 9'h1A5, 32'hDEADBEEF, 32'h0);
        op2("rd1a5", 1'b1, 1'b0, 9'h1A5, 32'h0, 32'hDEADBEEF);
        op2("rdwr010", 1'b1, 1'b1, 9'h010, 32'h12345678, 32'hDEADBEEF);
        op2("rd010", 1'b1, 1'b0, 9'h010, 32'h0, 32'h12345678);
        op2("wr0ff", 1'b0, 1'b1, 9'h0FF, 32'h11112222, 32'h12345678);

        // Write that gets aborted by reset while still in WAIT.
        Write = 1'b1; Address = 9'h0FF; MDR_out = 32'hCAFEF00D;
        cyc();
        Write = 1'b0;
        chk("abort busy before", {31'd0, Busy}, 32'd1);
        Clear = 1'b0;
        #1;
        chk("abort busy", {31'd0, Busy}, 32'd0);
        chk("abort done", {31'd0, Done}, 32'd0);
        chk("abort mdatain", Mdatain, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("abort hold%0d done", i), {31'd0, Done}, 32'd0);
            chk($sformatf("abort hold%0d busy", i), {31'd0, Busy}, 32'd0);
        end
        Clear = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("post abort%0d done", i), {31'd0, Done}, 32'd0);
            chk($sformatf("post abort%0d busy", i), {31'd0, Busy}, 32'd0);
        end
        op2("rd0ff", 1'b1, 1'b0, 9'h0FF, 32'h0, 32'h11112222);

        // Zero-wait instance: single write, then a held read request.
        Write1 = 1'b1; Address1 = 9'h005; MDR1 = 32'hA5A5A5A5;
        cyc();
        Write1 = 1'b0; MDR1 = 32'h0;
        chk("ws0 wr busy e+0", {31'd0, Busy1}, 32'd1);
        chk("ws0 wr done e+0", {31'd0, Done1}, 32'd0);
        cyc();
        chk("ws0 wr done e+1", {31'd0, Done1}, 32'd1);
        chk("ws0 wr mdatain", Mdatain1, 32'h0);
        cyc();
        chk("ws0 wr busy e+2", {31'd0, Busy1}, 32'd0);
        chk("ws0 wr done e+2", {31'd0, Done1}, 32'd0);

        Read1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc();
            chk($sformatf("ws0 b2b done e+%0d", k), {31'd0, Done1}, (k % 3 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("ws0 b2b busy e+%0d", k), {31'd0, Busy1}, (k % 3 == 2) ? 32'd0 : 32'd1);
            if (k == 1) chk("ws0 rd mdatain", Mdatain1, 32'hA5A5A5A5);
        end
        Read1 = 1'b0;
        cyc();
        cyc();
        chk("ws0 final busy", {31'd0, Busy1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
